pipe_mw_reg: RTL and testbench

- Memory-to-writeback (MEM/WB) pipeline register of the 5-stage RISC core.
- Captures the M-stage control bits, load data, ALU result and destination register on each rising clock edge.
- Presents them to the W stage one cycle later.
- Purely sequential; no combinational path from any _M input to any _W output.

---
 rtl/pipe_mw_reg.sv | 60 ++++++
 tb/tb_pipe_mw_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_mw_reg.sv
// MEM/WB pipeline register: captures M-stage writeback fields, presents them to W one cycle later.
// Optional build macro PIPE_MW_STALL_EN adds a STALL_W hold input (CLR still wins).
module pipe_mw_reg #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             CLR,
`ifdef PIPE_MW_STALL_EN
    input  logic             STALL_W,
`endif
    input  logic             REG_WRITE_M,
    input  logic             MEM_TO_REG_M,
    input  logic [WIDTH-1:0] READ_DATA_M,
    input  logic [WIDTH-1:0] ALU_OUT_M,
    input  logic [4:0]       WRITE_REG_M,
    output logic             REG_WRITE_W,
    output logic             MEM_TO_REG_W,
    output logic [WIDTH-1:0] READ_DATA_W,
    output logic [WIDTH-1:0] ALU_OUT_W,
    output logic [4:0]       WRITE_REG_W
);

    logic             r_reg_write;
    logic             r_mem_to_reg;
    logic [WIDTH-1:0] r_read_data;
    logic [WIDTH-1:0] r_alu_out;
    logic [4:0]       r_write_reg;

    // Pipeline register: clear inserts a bubble, otherwise every field loads unconditionally.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_read_data  <= {WIDTH{1'b0}};
            r_alu_out    <= {WIDTH{1'b0}};
            r_write_reg  <= 5'd0;
`ifdef PIPE_MW_STALL_EN
        end else if (STALL_W) begin
            r_reg_write  <= r_reg_write;
            r_mem_to_reg <= r_mem_to_reg;
            r_read_data  <= r_read_data;
            r_alu_out    <= r_alu_out;
            r_write_reg  <= r_write_reg;
`endif
        end else begin
            r_reg_write  <= REG_WRITE_M;
            r_mem_to_reg <= MEM_TO_REG_M;
            r_read_data  <= READ_DATA_M;
            r_alu_out    <= ALU_OUT_M;
            r_write_reg  <= WRITE_REG_M;
        end
    end

    assign REG_WRITE_W  = r_reg_write;
    assign MEM_TO_REG_W = r_mem_to_reg;
    assign READ_DATA_W  = r_read_data;
    assign ALU_OUT_W    = r_alu_out;
    assign WRITE_REG_W  = r_write_reg;

endmodule

// File: tb/tb_pipe_mw_reg.sv
// Directed self-checking bench for pipe_mw_reg; stall steps are built only with PIPE_MW_STALL_EN.
module tb_pipe_mw_reg;

    localparam int WIDTH = 32;

    logic             clk_s = 1'b0;
    logic             clr_s;
    logic             stall_s;
    logic             rw_m_s;
    logic             m2r_m_s;
    logic [WIDTH-1:0] rd_m_s;
    logic [WIDTH-1:0] alu_m_s;
    logic [4:0]       wr_m_s;
    logic             rw_w_s;
    logic             m2r_w_s;
    logic [WIDTH-1:0] rd_w_s;
    logic [WIDTH-1:0] alu_w_s;
    logic [4:0]       wr_w_s;

    int n_vec = 0;
    int n_err = 0;

    // expected W-stage values, derived from what the bench drove
    logic             e_rw;
    logic             e_m2r;
    logic [WIDTH-1:0] e_rd;
    logic [WIDTH-1:0] e_alu;
    logic [4:0]       e_wr;

    always #5 clk_s = ~clk_s;

    pipe_mw_reg #(.WIDTH(WIDTH)) dut (
        .CLK          (clk_s),
        .CLR          (clr_s),
`ifdef PIPE_MW_STALL_EN
        .STALL_W      (stall_s),
`endif
        .REG_WRITE_M  (rw_m_s),
        .MEM_TO_REG_M (m2r_m_s),
        .READ_DATA_M  (rd_m_s),
        .ALU_OUT_M    (alu_m_s),
        .WRITE_REG_M  (wr_m_s),
        .REG_WRITE_W  (rw_w_s),
        .MEM_TO_REG_W (m2r_w_s),
        .READ_DATA_W  (rd_w_s),
        .ALU_OUT_W    (alu_w_s),
        .WRITE_REG_W  (wr_w_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".reg_write"},  {31'd0, rw_w_s},  {31'd0, e_rw});
        chk({tag, ".mem_to_reg"}, {31'd0, m2r_w_s}, {31'd0, e_m2r});
        chk({tag, ".read_data"},  rd_w_s,           e_rd);
        chk({tag, ".alu_out"},    alu_w_s,          e_alu);
        chk({tag, ".write_reg"},  {27'd0, wr_w_s},  {27'd0, e_wr});
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] wr);
        rw_m_s  = rw;
        m2r_m_s = m2r;
        rd_m_s  = rd;
        alu_m_s = alu;
        wr_m_s  = wr;
    endtask

    task automatic expect_inputs();
        e_rw  = rw_m_s;
        e_m2r = m2r_m_s;
        e_rd  = rd_m_s;
        e_alu = alu_m_s;
        e_wr  = wr_m_s;
    endtask

    task automatic expect_zero();
        e_rw  = 1'b0;
        e_m2r = 1'b0;
        e_rd  = 32'd0;
        e_alu = 32'd0;
        e_wr  = 5'd0;
    endtask

    task automatic edge_step();
        @(posedge clk_s);
        #1;
    endtask

    initial begin
        // reset with every input nonzero
        stall_s = 1'b0;
        clr_s   = 1'b1;
        drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 5'd31);
        edge_step();
        expect_zero();
        chk_all("reset");

        // pass-through, including "not before the edge"
        clr_s = 1'b0;
        drive(1'b1, 1'b0, 32'hA5A5A5A5, 32'h0000_1000, 5'd7);
        #2;
        chk_all("pass_before_edge");
        edge_step();
        e_rw = 1'b1; e_m2r = 1'b0; e_rd = 32'hA5A5A5A5; e_alu = 32'h0000_1000; e_wr = 5'd7;
        chk_all("pass_through");

        // back-to-back random traffic
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
            expect_inputs();
            edge_step();
            chk_all("b2b");
        end

        // mid-cycle glitch on ALU_OUT_M must never reach the output
        drive(1'b0, 1'b1, 32'h0F0F0F0F, 32'h1, 5'd12);
        edge_step();
        e_rw = 1'b0; e_m2r = 1'b1; e_rd = 32'h0F0F0F0F; e_alu = 32'h1; e_wr = 5'd12;
        chk_all("glitch_load");
        alu_m_s = 32'hFFFFFFFF;
        #2;
        chk("glitch_mid", alu_w_s, 32'h1);
        #1;
        alu_m_s = 32'h1;
        edge_step();
        chk("glitch_after", alu_w_s, 32'h1);

        // flush mid-stream, then resume capture
        drive(1'b1, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 5'd5);
        edge_step();
        e_rw = 1'b1; e_m2r = 1'b1; e_rd = 32'hCAFEF00D; e_alu = 32'hCAFEF00D; e_wr = 5'd5;
        chk_all("flush_preload");
        clr_s = 1'b1;
        drive(1'b1, 1'b1, 32'h11111111, 32'h11111111, 5'd17);
        edge_step();
        expect_zero();
        chk_all("flush");
        clr_s = 1'b0;
        drive(1'b0, 1'b1, 32'h22222222, 32'h33333333, 5'd18);
        edge_step();
        e_rw = 1'b0; e_m2r = 1'b1; e_rd = 32'h22222222; e_alu = 32'h33333333; e_wr = 5'd18;
        chk_all("flush_resume");

        // WRITE_REG captured even with REG_WRITE_M low
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd21);
        edge_step();
        chk("no_gating.write_reg", {27'd0, wr_w_s}, 32'd21);

`ifdef PIPE_MW_STALL_EN
        drive(1'b1, 1'b0, 32'h44444444, 32'h55555555, 5'd3);
        edge_step();
        e_rw = 1'b1; e_m2r = 1'b0; e_rd = 32'h44444444; e_alu = 32'h55555555; e_wr = 5'd3;
        chk_all("stall_preload");
        stall_s = 1'b1;
        drive(1'b0, 1'b1, 32'h66666666, 32'h77777777, 5'd9);
        for (int k = 0; k < 3; k++) begin
            edge_step();
            chk_all("stall_hold");
        end
        clr_s = 1'b1;
        edge_step();
        expect_zero();
        chk_all("stall_clr_priority");
        clr_s   = 1'b0;
        stall_s = 1'b0;
        edge_step();
        expect_inputs();
        chk_all("stall_release");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
